// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory-side blocks.
// Word type and the memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a pending fetch is forced in after STARVE_LIMIT data grants.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  lc3b_word   i_addr,
  output logic       i_resp,
  input  logic       d_read,
  input  logic       d_write,
  input  lc3b_word   d_addr,
  input  lc3b_word   d_wdata,
  input  logic [1:0] d_wmask,
  output logic       d_resp,
  output lc3b_word   rdata,
  output logic       mem_read,
  output logic       mem_write,
  output lc3b_word   mem_address,
  output lc3b_word   mem_wdata,
  output logic [1:0] mem_wmask,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  lc3b_arb_state   state;
  lc3b_arb_state   state_n;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_n;
  logic            d_req;

  assign rdata = mem_rdata;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
    end
  end

  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    unique case (state)
      IDLE: begin
        if (i_read && (!d_req || starve_cnt == LIMIT)) begin
          state_n  = I_BUSY;
          starve_n = '0;
        end else if (d_req) begin
          state_n = D_BUSY;
          if (i_read && starve_cnt != LIMIT)
            starve_n = starve_cnt + CW'(1);
        end
      end
      I_BUSY: begin
        mem_read    = 1'b1;
        mem_address = i_addr;
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_n = IDLE;
        end
      end
      D_BUSY: begin
        mem_read    = d_read;
        mem_write   = d_write;
        mem_address = d_addr;
        mem_wdata   = d_wdata;
        mem_wmask   = d_wmask;
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // reset silences the port in the same cycle it is asserted
    if (rst) begin
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter STARVE_LIMIT, default 4: the number of consecutive data grants allowed while an instruction fetch is pending.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port i_read, input, 1 bit: fetch-stage read request; held until i_resp.
REQ-006 The block SHALL have port i_addr, input, lc3b_word: fetch address.
REQ-007 The block SHALL have port i_resp, output, 1 bit: one-cycle pulse when the fetch completes.
REQ-008 The block SHALL have port d_read, input, 1 bit: mem/wb-stage read request (LDR, LDB, LDI both cycles); held until d_resp.
REQ-009 The block SHALL have port d_write, input, 1 bit: mem/wb-stage write request; held until d_resp.
REQ-010 The block SHALL have port d_addr, input, lc3b_word: data address.
REQ-011 The block SHALL have port d_wdata, input, lc3b_word: store data.
REQ-012 The block SHALL have port d_wmask, input, 2 bits: byte-enable mask.
REQ-013 The block SHALL have port d_resp, output, 1 bit: one-cycle pulse when the data access completes; this is the stage's data_response.
REQ-014 The block SHALL have port rdata, output, lc3b_word: mem_rdata passthrough to both requesters.
REQ-015 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each: the shared memory strobes.
REQ-016 The block SHALL have port mem_address, output, lc3b_word: shared memory address.
REQ-017 The block SHALL have ports mem_wdata (output, lc3b_word) and mem_wmask (output, 2 bits): shared memory write data and byte mask.
REQ-018 The block SHALL have port mem_rdata, input, lc3b_word: shared memory read data.
REQ-019 The block SHALL have port mem_resp, input, 1 bit: shared memory completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, I_BUSY and D_BUSY, registered.
REQ-021 In IDLE, on (d_read|d_write) with no starvation override, the next state SHALL be D_BUSY.
REQ-022 In IDLE, the next state SHALL be I_BUSY if i_read and either no data request is pending or starve_cnt == STARVE_LIMIT.
REQ-023 In IDLE, with no requests, the block SHALL stay in IDLE.
REQ-024 In IDLE, all mem_* strobes SHALL be 0 and mem_resp SHALL be ignored.
REQ-025 In I_BUSY: mem_read = 1, mem_write = 0, mem_address = i_addr.
REQ-026 In D_BUSY: mem_read = d_read, mem_write = d_write, mem_address = d_addr, mem_wdata = d_wdata, mem_wmask = d_wmask.
REQ-027 In a busy state, mem_resp SHALL combinationally pulse only the granted requester's resp in the same cycle, and the next state SHALL be IDLE.
REQ-028 The block SHALL insert one mandatory IDLE cycle between transactions: grant occurs the cycle after a request is seen in IDLE, and the minimum request-to-resp time is 1 cycle plus memory latency.
REQ-029 Once granted, a transaction SHALL be held until mem_resp even if the requester deasserts; requester deassertion mid-transaction is illegal and needs no recovery.
REQ-030 rdata SHALL equal mem_rdata at all times.
REQ-031 starve_cnt SHALL be ceil(log2(STARVE_LIMIT+1)) bits wide.
REQ-032 starve_cnt SHALL increment on each D grant taken while i_read = 1, saturating at STARVE_LIMIT.
REQ-033 starve_cnt SHALL clear on any I grant and SHALL hold otherwise.
REQ-034 For LDI/STI, the second data cycle SHALL re-arbitrate like any other request, so an override fetch may be inserted between the two cycles.

Reset
REQ-035 On rst, state SHALL be IDLE and starve_cnt SHALL be 0.
REQ-036 During and after reset, all mem_* strobes, i_resp and d_resp SHALL be 0.
REQ-037 rst mid-transaction SHALL abandon the transaction: strobes are low the cycle after rst, and a later mem_resp is ignored.
REQ-038 rst SHALL take priority over every other input.

Structure
REQ-039 lc3b_word and a new enum lc3b_arb_state SHALL live in lc3b_types; STARVE_LIMIT stays a module parameter.
REQ-040 The block SHALL be flat with no sub-module; one always_ff block for state and counter, one always_comb block for muxing and strobes.

Verification
REQ-041 Scenario: i_read only, i_addr = 0x3000, mem_resp 3 cycles after grant -> mem_read high in cycles 1-3, mem_address = 0x3000, i_resp pulses once, d_resp = 0.
REQ-042 Scenario: i_read and d_write raised in the same cycle, d_addr = 0x4000, d_wdata = 0xBEEF, d_wmask = 2'b11 -> D served first with mem_write = 1 and mem_wdata = 0xBEEF, then one IDLE cycle, then the I fetch.
REQ-043 Scenario: STARVE_LIMIT = 4, d_read and i_read held continuously -> exactly 4 D grants, then 1 I grant, then starve_cnt = 0.
REQ-044 Scenario: LDI, i.e. d_read held across two responses with i_read low -> two D transactions, d_resp pulses twice, IDLE gap of 1 cycle.
REQ-045 Scenario: rst asserted in D_BUSY, then mem_resp arrives 1 cycle later -> no d_resp, state IDLE, strobes 0.
REQ-046 Scenario: mem_resp pulsed in IDLE with no requests -> no i_resp or d_resp, and the state is unchanged.
